// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the slave responder state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

endpackage

// File: rtl/ahb_slave_wordmem.sv
// Word array with per-byte write enables and combinational read.
module ahb_slave_wordmem #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] idx,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite memory slave: wait states, ERROR on illegal access,
// little-endian byte lanes over a word-organised array.
module ahb_lite_slave_mem
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_LSB    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic [31:0] o_hrdata,
    output logic        o_hreadyout,
    output logic        o_hresp
);

    localparam int AW = $clog2(DEPTH);
    localparam int QW = ADDR_LSB + AW;

    slv_state_e    state;
    logic [3:0]    cnt;
    logic [QW-1:0] addr_q;
    logic          write_q;
    logic [2:0]    size_q;

    logic          accept;
    logic          legal;
    logic          aligned;
    logic          in_range;
    logic [31:0]   word_idx;
    logic [3:0]    be;
    logic [3:0]    we;
    logic [31:0]   mem_rdata;

    // Only states that drive HREADYOUT high can open a new address phase.
    assign accept = (state inside {ST_IDLE, ST_DATA, ST_ERR2})
                  & i_hsel & i_hready & i_htrans[1];

    assign word_idx = i_haddr >> ADDR_LSB;
    assign in_range = word_idx < 32'(DEPTH);

    always_comb begin
        aligned = 1'b1;
        if (i_hsize == HSIZE_HALF) aligned = ~i_haddr[0];
        else if (i_hsize == HSIZE_WORD) aligned = (i_haddr[1:0] == 2'b00);
    end

    assign legal = in_range & (i_hsize <= HSIZE_WORD) & aligned;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            o_hreadyout <= 1'b1;
            o_hresp     <= HRESP_OKAY;
        end else if (accept) begin
            addr_q  <= i_haddr[QW-1:0];
            write_q <= i_hwrite;
            size_q  <= i_hsize;
            if (!legal) begin
                state       <= ST_ERR1;
                o_hreadyout <= 1'b0;
                o_hresp     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
                state       <= ST_WAIT;
                cnt         <= 4'(WAIT_STATES);
                o_hreadyout <= 1'b0;
                o_hresp     <= HRESP_OKAY;
            end else begin
                state       <= ST_DATA;
                o_hreadyout <= 1'b1;
                o_hresp     <= HRESP_OKAY;
            end
        end else begin
            unique case (state)
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state       <= ST_DATA;
                        o_hreadyout <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    o_hreadyout <= 1'b1;
                    o_hresp     <= HRESP_ERROR;
                end
                default: begin
                    state       <= ST_IDLE;
                    o_hreadyout <= 1'b1;
                    o_hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

    always_comb begin
        unique case (size_q)
            HSIZE_BYTE: be = 4'b0001 << addr_q[1:0];
            HSIZE_HALF: be = addr_q[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
    end

    assign we = (state == ST_DATA && write_q) ? be : 4'b0000;

    ahb_slave_wordmem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk   (i_clk),
        .idx   (addr_q[ADDR_LSB +: AW]),
        .be    (we),
        .wdata (i_hwdata),
        .rdata (mem_rdata)
    );

    assign o_hrdata = (state == ST_DATA && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Scoreboard bench: two slaves (0 and 3 wait states) on one driven bus.
module tb_ahb_lite_slave_mem;
    import ahb_pkg::*;

    typedef struct {
        string       name;
        logic        resp;
        logic [31:0] data;
        int          lows;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        use3;
    logic        force_nrdy;

    logic [31:0] rd0, rd3;
    logic        ro0, ro3, rs0, rs3;
    logic        ro_act, rs_act, hready_bus;
    logic [31:0] rd_act;

    exp_t sb[$];
    exp_t e;
    bit   acc;
    bit   pend;
    bit   done;
    bit   done_seen;
    int   lows;
    int   n_chk;
    int   n_fail;

    assign ro_act     = use3 ? ro3 : ro0;
    assign rs_act     = use3 ? rs3 : rs0;
    assign rd_act     = use3 ? rd3 : rd0;
    assign hready_bus = ro_act & ~force_nrdy;

    ahb_lite_slave_mem #(
        .DEPTH(256), .WAIT_STATES(0), .ADDR_LSB(2)
    ) dut0 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_hsel      (hsel & ~use3),
        .i_haddr     (haddr),
        .i_htrans    (htrans),
        .i_hwrite    (hwrite),
        .i_hsize     (hsize),
        .i_hwdata    (hwdata),
        .i_hready    (hready_bus),
        .o_hrdata    (rd0),
        .o_hreadyout (ro0),
        .o_hresp     (rs0)
    );

    ahb_lite_slave_mem #(
        .DEPTH(256), .WAIT_STATES(3), .ADDR_LSB(2)
    ) dut3 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_hsel      (hsel & use3),
        .i_haddr     (haddr),
        .i_htrans    (htrans),
        .i_hwrite    (hwrite),
        .i_hsize     (hsize),
        .i_hwdata    (hwdata),
        .i_hready    (hready_bus),
        .o_hrdata    (rd3),
        .o_hreadyout (ro3),
        .o_hresp     (rs3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(string n, logic r, logic [31:0] d, int l);
        exp_t x;
        x.name = n;
        x.resp = r;
        x.data = d;
        x.lows = l;
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // A transfer is accepted at the edge where the bus saw select, ready and NONSEQ.
    always @(posedge clk) acc <= rst_n & hsel & hready_bus & htrans[1];

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
            sb.delete();
            chk("rst_rdy0", 32'(ro0), 32'd1);
            chk("rst_resp0", 32'(rs0), 32'd0);
            chk("rst_data0", rd0, 32'd0);
            chk("rst_rdy3", 32'(ro3), 32'd1);
            chk("rst_resp3", 32'(rs3), 32'd0);
            chk("rst_data3", rd3, 32'd0);
        end else begin
            if (acc) begin
                pend = 1'b1;
                lows = 0;
            end
            if (pend) begin
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got data phase, expected none");
                    pend = 1'b0;
                end else if (!ro_act) begin
                    lows++;
                    chk({sb[0].name, "_wresp"}, 32'(rs_act), 32'(sb[0].resp));
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_resp"}, 32'(rs_act), 32'(e.resp));
                    chk({e.name, "_data"}, rd_act, e.data);
                    chk({e.name, "_lows"}, 32'(lows), 32'(e.lows));
                    pend = 1'b0;
                end
            end else begin
                chk("idle_rdy", 32'(ro_act), 32'd1);
                chk("idle_resp", 32'(rs_act), 32'd0);
                chk("idle_data", rd_act, 32'd0);
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                chk("sb_drained", 32'(sb.size()), 32'd0);
            end
        end
    end

    task automatic xfer(logic w, logic [31:0] a, logic [2:0] sz,
                        logic [31:0] wd, exp_t x);
        bit r;
        int n;
        n = 0;
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = w;
        haddr  = a;
        hsize  = sz;
        do begin
            @(negedge clk);
            r = hready_bus;
            @(posedge clk);
            n++;
        end while (!r && n < 50);
        #1;
        if (!r) begin
            $display("FAIL xfer_timeout %h: hready low, expected high", a);
            $fatal(1, "bus hung");
        end
        sb.push_back(x);
        if (w) hwdata = wd;
    endtask

    task automatic idle(logic [1:0] tr, int n);
        hsel   = (tr != HTRANS_IDLE);
        htrans = tr;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        hsel       = 1'b0;
        haddr      = '0;
        htrans     = HTRANS_IDLE;
        hwrite     = 1'b0;
        hsize      = HSIZE_WORD;
        hwdata     = '0;
        use3       = 1'b0;
        force_nrdy = 1'b0;
        done       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back write then read of the same word.
        xfer(1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, mk("t1_wr", 0, 0, 0));
        xfer(0, 32'h10, HSIZE_WORD, 0, mk("t1_rd", 0, 32'hDEADBEEF, 0));
        idle(HTRANS_IDLE, 3);

        // Byte and halfword lanes; other lanes carry junk.
        xfer(1, 32'h10, HSIZE_WORD, 32'h0, mk("t2_clr0", 0, 0, 0));
        xfer(1, 32'h14, HSIZE_WORD, 32'h0, mk("t2_clr1", 0, 0, 0));
        xfer(1, 32'h11, HSIZE_BYTE, 32'h1122AA33, mk("t2_byte", 0, 0, 0));
        xfer(1, 32'h16, HSIZE_HALF, 32'h55667788, mk("t2_half", 0, 0, 0));
        xfer(0, 32'h10, HSIZE_WORD, 0, mk("t2_rd10", 0, 32'h0000AA00, 0));
        xfer(0, 32'h14, HSIZE_WORD, 0, mk("t2_rd14", 0, 32'h55660000, 0));
        idle(HTRANS_IDLE, 3);

        // Three wait states, BUSY ignored while stalled.
        use3 = 1'b1;
        xfer(1, 32'h20, HSIZE_WORD, 32'h12345678, mk("t3_wr", 0, 0, 3));
        xfer(0, 32'h20, HSIZE_WORD, 0, mk("t3_rd", 0, 32'h12345678, 3));
        idle(HTRANS_BUSY, 4);
        idle(HTRANS_IDLE, 2);

        // Illegal accesses answer with the two-cycle ERROR.
        use3 = 1'b0;
        xfer(0, 32'h400, HSIZE_WORD, 0, mk("t4_range", 1, 0, 1));
        xfer(0, 32'h12, HSIZE_WORD, 0, mk("t4_algn_w", 1, 0, 1));
        xfer(0, 32'h10, 3'd3, 0, mk("t4_size3", 1, 0, 1));
        xfer(1, 32'h13, HSIZE_HALF, 32'hFFFFFFFF, mk("t4_algn_h", 1, 0, 1));
        xfer(1, 32'h3FC, HSIZE_WORD, 32'h01020304, mk("t4_top_wr", 0, 0, 0));
        xfer(0, 32'h3FC, HSIZE_WORD, 0, mk("t4_top_rd", 0, 32'h01020304, 0));
        xfer(0, 32'h10, HSIZE_WORD, 0, mk("t4_nowr", 0, 32'h0000AA00, 0));
        idle(HTRANS_IDLE, 3);

        // Reset during wait states drops the pending write.
        use3 = 1'b1;
        xfer(1, 32'h20, HSIZE_WORD, 32'hCAFEF00D, mk("t5_wr", 0, 0, 3));
        idle(HTRANS_IDLE, 1);
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(0, 32'h20, HSIZE_WORD, 0, mk("t5_rd", 0, 32'h12345678, 3));
        idle(HTRANS_IDLE, 6);

        // Select with bus HREADY low must not open a transfer.
        use3       = 1'b0;
        force_nrdy = 1'b1;
        hsel       = 1'b1;
        htrans     = HTRANS_NONSEQ;
        hwrite     = 1'b0;
        haddr      = 32'h400;
        hsize      = HSIZE_WORD;
        repeat (3) @(posedge clk);
        #1;
        force_nrdy = 1'b0;
        idle(HTRANS_IDLE, 3);

        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
